// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op codes, the sequencer state encoding and the
// op-class helper that decides which ops need the multi-cycle sequencer.
// Ports: none (package).
package fpu_pkg;

  localparam logic [4:0] FPU_OP_DIV  = 5'd3;
  localparam logic [4:0] FPU_OP_SQRT = 5'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Anything not explicitly long-latency, including undefined codes, is
  // treated as a single-cycle op and bypasses the sequencer.
  function automatic logic is_multicycle(input logic [4:0] sel);
    return (sel == FPU_OP_DIV) || (sel == FPU_OP_SQRT);
  endfunction

endpackage

// File: rtl/fpu_op_sequencer.sv
// Purpose: issue/stall controller wrapping FDIV/FSQRT on the EX-stage FPU.
// Latency: single-cycle ops 0 added; multi-cycle ops stall LAT+1 cycles, then
//          a one-cycle registered result (result_valid) in cycle LAT+1.
// Backpressure: stall freezes IF/ID/EX while the op runs; flush drops it.
// Ports: issue_valid/sel_fpu/src_a/src_b/rd_in from EX, flush from the hazard
//        logic, fpu_result from the FPU; fpu_a/fpu_b/fpu_ctrl to the FPU,
//        stall/busy to the hazard unit, result_valid/result/rd_out to EX/MEM.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  sel_fpu,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic [31:0] fpu_result,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [4:0]  fpu_ctrl,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // Counter holds LAT-1 on the first RUN cycle, so RUN lasts exactly LAT cycles.
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_LAT - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q;
  logic [4:0]       op_q, rd_q;
  logic             start;

  // Only meaningful in IDLE; RUN/DONE ignore issue_valid because the same
  // instruction is still parked in EX.
  assign start = issue_valid && is_multicycle(sel_fpu) && !flush;
  assign busy  = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fpu_a        = src_a;
    fpu_b        = src_b;
    fpu_ctrl     = sel_fpu;
    stall        = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: stall = start;
      RUN: begin
        fpu_a    = a_q;
        fpu_b    = b_q;
        fpu_ctrl = op_q;
        stall    = !flush;
      end
      DONE: begin
        fpu_a        = a_q;
        fpu_b        = b_q;
        fpu_ctrl     = op_q;
        result_valid = !flush;
      end
      default: ;
    endcase
  end

  // Operand capture, latency counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        a_q   <= src_a;
        b_q   <= src_b;
        op_q  <= sel_fpu;
        rd_q  <= rd_in;
        cnt_q <= (sel_fpu == FPU_OP_DIV) ? DIV_LOAD : SQRT_LOAD;
      end
      // A flushed op must never reach the result register.
      if (state_q == RUN && !flush) begin
        if (cnt_q == '0) begin
          result <= fpu_result;
          rd_out <= rd_q;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: single-cycle bypass, FDIV/FSQRT
// timing, back-to-back issue, flush and asynchronous reset mid-op.
module tb_fpu_op_sequencer;

  localparam int DIV_LAT  = 8;
  localparam int SQRT_LAT = 12;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  sel_fpu;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic [31:0] fpu_result;
  logic [31:0] fpu_a, fpu_b;
  logic [4:0]  fpu_ctrl;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  // Bench model of the result registers.
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd     = '0;

  fpu_op_sequencer #(.DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .sel_fpu(sel_fpu),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .flush(flush),
    .fpu_result(fpu_result), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is at the start of cycle 0. Drives one multi-cycle op through
  // DONE (or through a flush at cycle flush_at when flush_at > 0) and
  // returns at the start of the following cycle with issue_valid still set
  // for the normal case. The FPU model returns res only in cycle lat.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input logic [31:0] res,
                       input int flush_at);
    bit flushed = 1'b0;
    for (int c = 0; c <= lat + 1; c++) begin
      issue_valid = 1'b1;
      sel_fpu     = op;
      rd_in       = rd;
      src_a       = (c == 0) ? a : (a ^ 32'h0F0F_0F0F);
      src_b       = (c == 0) ? b : (b ^ 32'hF0F0_F0F0);
      fpu_result  = (c == lat) ? res : (32'hBAD0_0000 | 32'(c));
      flush       = (flush_at != 0) && (c == flush_at);
      if (flush) issue_valid = 1'b0;
      @(negedge clk);
      if (flush) begin
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_rv", 32'(result_valid), 32'd0);
        step();
        flushed = 1'b1;
        break;
      end
      chk("op_stall", 32'(stall), 32'(c <= lat));
      chk("op_rv", 32'(result_valid), 32'(c == lat + 1));
      chk("op_busy", 32'(busy), 32'(c >= 1));
      chk("op_fpu_a", fpu_a, a);
      chk("op_fpu_b", fpu_b, b);
      chk("op_fpu_ctrl", 32'(fpu_ctrl), 32'(op));
      if (c == lat + 1) begin
        chk("op_result", result, res);
        chk("op_rd_out", 32'(rd_out), 32'(rd));
      end
      step();
    end
    if (flushed) begin
      issue_valid = 1'b0;
      flush       = 1'b0;
      fpu_result  = res;
      for (int c = 0; c < lat + 2; c++) begin
        @(negedge clk);
        chk("postflush_busy", 32'(busy), 32'd0);
        chk("postflush_rv", 32'(result_valid), 32'd0);
        chk("postflush_result", result, exp_result);
        step();
      end
    end else begin
      exp_result = res;
      exp_rd     = rd;
    end
  endtask

  task automatic idle_cycle(input string tag);
    issue_valid = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    chk(tag, 32'(busy), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    step();
  endtask

  logic [4:0]  sc_op [4] = '{5'd0, 5'd1, 5'd31, 5'd2};
  logic [31:0] sc_a  [4] = '{32'h3F80_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001};
  logic [31:0] sc_b  [4] = '{32'h4000_0000, 32'h8765_4321, 32'h0000_0000, 32'h8000_0000};

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; sel_fpu = '0; src_a = '0; src_b = '0;
    rd_in = '0; flush = 1'b0; fpu_result = '0;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single-cycle ops, including an undefined code, pass straight through
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; sel_fpu = sc_op[i]; src_a = sc_a[i]; src_b = sc_b[i];
      rd_in = 5'(i + 1); fpu_result = 32'hCAFE_0000;
      @(negedge clk);
      chk("sc_fpu_a", fpu_a, sc_a[i]);
      chk("sc_fpu_b", fpu_b, sc_b[i]);
      chk("sc_fpu_ctrl", 32'(fpu_ctrl), 32'(sc_op[i]));
      chk("sc_stall", 32'(stall), 32'd0);
      chk("sc_rv", 32'(result_valid), 32'd0);
      chk("sc_busy", 32'(busy), 32'd0);
      step();
    end

    // FDIV 4.0 / 2.0 -> 2.0, rd 7; operands change while running
    do_op(5'd3, 32'h4080_0000, 32'h4000_0000, 5'd7, DIV_LAT, 32'h4000_0000, 0);
    idle_cycle("fdiv_busy_after");

    // Back-to-back FDIV: second op issues in cycle LAT+2 of the first
    do_op(5'd3, 32'h4120_0000, 32'h4000_0000, 5'd9,  DIV_LAT, 32'h40A0_0000, 0);
    do_op(5'd3, 32'h40C0_0000, 32'h4040_0000, 5'd12, DIV_LAT, 32'h4000_0000, 0);
    idle_cycle("b2b_busy_after");

    // FSQRT 9.0 -> 3.0, rd 5
    do_op(5'd4, 32'h4110_0000, 32'h0000_0000, 5'd5, SQRT_LAT, 32'h4040_0000, 0);
    idle_cycle("fsqrt_busy_after");

    // FSQRT flushed in RUN cycle 4: result must keep 3.0
    do_op(5'd4, 32'h4180_0000, 32'h0000_0000, 5'd3, SQRT_LAT, 32'h4080_0000, 4);
    chk("flush_keep_result", result, 32'h4040_0000);

    // Asynchronous reset during RUN cycle 3
    issue_valid = 1'b1; sel_fpu = 5'd3; src_a = 32'h4080_0000; src_b = 32'h4000_0000;
    rd_in = 5'd11; fpu_result = 32'h4000_0000;
    step(); step(); step();
    #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_rv", 32'(result_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd_out", 32'(rd_out), 32'd0);
    exp_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int c = 0; c < DIV_LAT + 3; c++) begin
      @(negedge clk);
      chk("postrst_rv", 32'(result_valid), 32'd0);
      chk("postrst_result", result, exp_result);
      chk("postrst_busy", 32'(busy), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Issue and stall controller for multi-cycle FPU operations in the Execute/Memory stage. Single-cycle FPU and ALU operations pass through untouched. FDIV and FSQRT ops are handled as follows:
- the block latches their operands and destination register;
- it holds the pipeline stalled for a fixed latency;
- it presents a registered, tagged result for exactly one cycle so the EX/MEM register can capture it.

It sits between the EX-stage control signals (`DSrc`, `selFPU`) and the FPU. It drives the FPU operand and control inputs, and feeds the hazard unit's stall input.

## Interface
Parameters:
- `DIV_LAT`, 8: FDIV latency in cycles, ≥1.
- `SQRT_LAT`, 12: FSQRT latency in cycles, ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  EX holds a valid FPU instruction (`DSrc`=1).
- `sel_fpu`  in  5  FPU op code from decode.
- `src_a`, `src_b`  in  32  forwarded FPU operands (`SrcAF`/`SrcBF`).
- `rd_in`  in  5  destination register of the EX instruction.
- `flush`  in  1  kill the in-flight op (branch/exception).
- `fpu_result`  in  32  FPU output.
- `fpu_a`, `fpu_b`  out  32  operands to the FPU.
- `fpu_ctrl`  out  5  `FPUControl` to the FPU.
- `stall`  out  1  freeze IF/ID/EX.
- `busy`  out  1  state ≠ IDLE.
- `result_valid`  out  1  multi-cycle result ready this cycle.
- `result`  out  32  registered multi-cycle result.
- `rd_out`  out  5  destination tag of `result`.

## Operation
- Op class:
  - multi-cycle = `sel_fpu` ∈ {`FPU_OP_DIV`, `FPU_OP_SQRT`};
  - all other codes, including undefined ones, are single-cycle.
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `fpu_a`/`fpu_b`/`fpu_ctrl` = `src_a`/`src_b`/`sel_fpu` (combinational pass-through).
  - If `issue_valid` & multi-cycle & !`flush`:
    - `stall`=1 this cycle;
    - capture operands, op and `rd_in` into internal registers;
    - load the counter with LAT−1 for the op (`DIV_LAT` or `SQRT_LAT`);
    - next state RUN.
  - Otherwise `stall`=0 and the state stays IDLE.
- **RUN**
  - `fpu_*` driven from the captured registers; `stall`=1.
  - Counter decrements each cycle.
  - When counter==0: capture `fpu_result` into `result` and go to DONE.
- **DONE**
  - `result_valid`=1 and `stall`=0, so the pipeline advances and EX/MEM latches `result`/`rd_out`.
  - `issue_valid` is ignored here, because the same instruction is still in EX.
  - Next state IDLE.
- **Flush**
  - `flush`=1 in RUN or DONE forces `stall`=0 and `result_valid`=0 combinationally that cycle; next state IDLE.
  - `result` is not updated.
- Counter width: $clog2(max(`DIV_LAT`,`SQRT_LAT`)), minimum 1 bit.

## Timing
- **Reset values:** state IDLE; `result`=0; `rd_out`=0; captured operands/op=0; `busy`=0; `stall`=0; `result_valid`=0.
- **Reset mid-RUN:** the op is abandoned and no `result_valid` is produced.
- **Multi-cycle op issued in cycle 0:**
  - cycle 0: IDLE, `stall`=1.
  - cycles 1..LAT: RUN, `stall`=1.
  - cycle LAT+1: DONE, `result_valid`=1, `stall`=0.
  - cycle LAT+2: a new instruction in EX, which may issue immediately.
- The FPU sees stable operands from cycle 0 through cycle LAT. `fpu_result` is sampled at the end of cycle LAT.
- **Single-cycle ops:** zero added latency; `stall` and `result_valid` stay 0.
- `stall` is a combinational output. `result`/`rd_out` are register outputs.

## Structure
- Shared package `fpu_pkg`:
  - `FPU_OP_DIV`=5'd3, `FPU_OP_SQRT`=5'd4;
  - the FSM state enum (IDLE/RUN/DONE);
  - the op-class helper function `is_multicycle(sel)`.
- No sub-module: FSM, counter and capture registers live in one module. The FPU itself stays instantiated in Execute/Memory.

## Test plan
1. **FDIV.** `DIV_LAT`=8; issue FDIV with a=0x40800000 (4.0), b=0x40000000 (2.0), `rd_in`=7 at cycle 0. Required:
   - `stall`=1 in cycles 0–8;
   - `result_valid`=1 in cycle 9 with `result`=0x40000000 and `rd_out`=7;
   - `busy`=0 in cycle 10.
2. **Single-cycle op.** FADD issue (`sel_fpu`=5'd0). Required: `stall`=0, `result_valid`=0 every cycle, and `fpu_a`/`fpu_b` equal to `src_a`/`src_b` in the same cycle.
3. **Flush.** FSQRT (`SQRT_LAT`=12), flush in RUN cycle 4. Required: `stall`=0 that cycle, IDLE next cycle, no `result_valid` pulse, `result` unchanged.
4. **Back-to-back FDIV.** Required:
   - the second op starts in cycle 10;
   - its `result_valid` is in cycle 19;
   - the DONE cycle does not re-trigger on the still-high `issue_valid`.
5. **Async reset.** Drive `rst_n` low asynchronously during RUN cycle 3. Required: all outputs at reset values immediately, and no stale result after release.
6. **Operand stability.** Change `src_a`/`src_b` while RUN. Required: `fpu_a`/`fpu_b` hold the captured values until DONE.
